// File: rtl/pipe_mem_arbiter.sv
// Arbitrates one single-ported memory between IF fetch and MEM lw/sw (data first); optional FETCH_BUF_EN fetch buffer.
// Latency: LAT+2 cycles from request to ready pulse (IDLE, LAT access cycles, DONE); buffer hits complete in the request cycle.
// Backpressure: requests are held until ready; stall freezes the pipeline while any request is unserved.
module pipe_mem_arbiter #(
  parameter int LAT = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall
);

  localparam int CW = $clog2(LAT) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_ACC  = 3'd1,
    I_ACC  = 3'd2,
    D_DONE = 3'd3,
    I_DONE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          buf_hit;
  logic          acc_last;

  assign acc_last = (cnt_q == '0);

`ifdef FETCH_BUF_EN
  logic          buf_valid;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_data;

  // A hit is served combinationally and never touches the memory; data requests still win.
  assign buf_hit = ~reset && (state_q == IDLE) && !d_req && if_req &&
                   buf_valid && (if_addr == buf_addr);

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (state_q == I_ACC && acc_last) begin
      buf_valid <= 1'b1;
      buf_addr  <= addr_q;
      buf_data  <= mem_rdata;
    end else if (state_q == IDLE && d_req && d_we && d_addr == buf_addr) begin
      buf_valid <= 1'b0;
    end
  end

  assign if_rdata = buf_hit ? buf_data : if_rdata_q;
`else
  assign buf_hit  = 1'b0;
  assign if_rdata = if_rdata_q;
`endif

  assign d_rdata = d_rdata_q;
  assign stall   = (if_req & ~if_ready) | (d_req & ~d_ready);

  always_comb begin
    state_d   = state_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_ready  = buf_hit;
    d_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req)                  state_d = D_ACC;
        else if (if_req && !buf_hit) state_d = I_ACC;
      end
      D_ACC: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (acc_last) state_d = D_DONE;
      end
      I_ACC: begin
        mem_en    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (acc_last) state_d = I_DONE;
      end
      // No access starts here so the next request line belongs to the next instruction.
      D_DONE: begin
        d_ready = 1'b1;
        state_d = IDLE;
      end
      I_DONE: begin
        if_ready = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (d_req) begin
            addr_q  <= d_addr;
            we_q    <= d_we;
            wdata_q <= d_wdata;
            cnt_q   <= CW'(LAT - 1);
          end else if (if_req && !buf_hit) begin
            addr_q <= if_addr;
            we_q   <= 1'b0;
            cnt_q  <= CW'(LAT - 1);
          end
        end
        D_ACC: begin
          if (acc_last) begin
            if (!we_q) d_rdata_q <= mem_rdata;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        I_ACC: begin
          if (acc_last) if_rdata_q <= mem_rdata;
          else          cnt_q      <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed per-cycle vectors for pipe_mem_arbiter (LAT=2), plus sequences for latency and dropped-request corner cases.
module tb_pipe_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_mem_arbiter #(.LAT(2), .AW(32), .DW(32)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, ireq;
    logic [31:0] iaddr;
    logic        dreq, dwe;
    logic [31:0] daddr, dwd, mrd;
    logic        en, we;
    logic [31:0] maddr, mwd;
    logic        ir;
    logic [31:0] ird;
    logic        dr;
    logic [31:0] drd;
    logic        st;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic rst, input logic ireq, input logic [31:0] iaddr,
                     input logic dreq, input logic dwe, input logic [31:0] daddr,
                     input logic [31:0] dwd, input logic [31:0] mrd,
                     input logic en, input logic we, input logic [31:0] maddr,
                     input logic [31:0] mwd, input logic ir, input logic [31:0] ird,
                     input logic dr, input logic [31:0] drd, input logic st);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe;
    v.daddr = daddr; v.dwd = dwd; v.mrd = mrd;
    v.en = en; v.we = we; v.maddr = maddr; v.mwd = mwd; v.ir = ir; v.ird = ird;
    v.dr = dr; v.drd = drd; v.st = st;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [132:0] act, input logic [132:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [132:0] outs();
    return {mem_en, mem_we, mem_addr, mem_wdata, if_ready, if_rdata, d_ready, d_rdata, stall};
  endfunction

  initial begin
    int k;
    logic [31:0] ia, da;
    ia = 32'h2008_0005;
    da = 32'hDEAD_BEEF;

    reset = 1'b1; if_req = 1'b1; if_addr = '0; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h300; d_wdata = '0; mem_rdata = '0;

    // rst ireq iaddr dreq dwe daddr dwd mrd | en we maddr mwd ir ird dr drd st
    // reset with both requests up, then data wins the first access
    row(1,1,0,1,0,32'h300,0,0,             0,0,0,0,0,0,0,0,1);
    row(1,1,0,1,0,32'h300,0,0,             0,0,0,0,0,0,0,0,1);
    row(0,1,0,1,0,32'h300,0,0,             0,0,0,0,0,0,0,0,1);
    row(0,1,0,1,0,32'h300,0,32'h1111,      1,0,32'h300,0,0,0,0,0,1);
    row(0,1,0,1,0,32'h300,0,32'hA5A5A5A5,  1,0,32'h300,0,0,0,0,0,1);
    row(0,1,0,1,0,32'h300,0,0,             0,0,0,0,0,0,1,32'hA5A5A5A5,1);
    row(0,0,0,0,0,0,0,0,                   0,0,0,0,0,0,0,32'hA5A5A5A5,0);
    // fetch only; only the last access cycle's mem_rdata is captured
    row(0,1,32'h10,0,0,0,0,0,              0,0,0,0,0,0,0,32'hA5A5A5A5,1);
    row(0,1,32'h10,0,0,0,0,32'hBAD0BAD0,   1,0,32'h10,0,0,0,0,32'hA5A5A5A5,1);
    row(0,1,32'h10,0,0,0,0,ia,             1,0,32'h10,0,0,0,0,32'hA5A5A5A5,1);
    row(0,1,32'h10,0,0,0,0,0,              0,0,0,0,1,ia,0,32'hA5A5A5A5,0);
    row(0,0,0,0,0,0,0,0,                   0,0,0,0,0,ia,0,32'hA5A5A5A5,0);
    // simultaneous fetch and load
    row(0,1,32'h14,1,0,32'h100,0,0,        0,0,0,0,0,ia,0,32'hA5A5A5A5,1);
    row(0,1,32'h14,1,0,32'h100,0,0,        1,0,32'h100,0,0,ia,0,32'hA5A5A5A5,1);
    row(0,1,32'h14,1,0,32'h100,0,da,       1,0,32'h100,0,0,ia,0,32'hA5A5A5A5,1);
    row(0,1,32'h14,1,0,32'h100,0,0,        0,0,0,0,0,ia,1,da,1);
    row(0,1,32'h14,0,0,0,0,0,              0,0,0,0,0,ia,0,da,1);
    row(0,1,32'h14,0,0,0,0,0,              1,0,32'h14,0,0,ia,0,da,1);
    row(0,1,32'h14,0,0,0,0,32'h8C0A0004,   1,0,32'h14,0,0,ia,0,da,1);
    row(0,1,32'h14,0,0,0,0,0,              0,0,0,0,1,32'h8C0A0004,0,da,0);
    row(0,0,0,0,0,0,0,0,                   0,0,0,0,0,32'h8C0A0004,0,da,0);
    // store; address/data come from the latch even if the inputs wander
    row(0,0,0,1,1,32'h200,32'h12345678,0,          0,0,0,0,0,32'h8C0A0004,0,da,1);
    row(0,0,0,1,1,32'h999,0,0,                     1,1,32'h200,32'h12345678,0,32'h8C0A0004,0,da,1);
    row(0,0,0,1,1,32'h999,0,32'hFFFFFFFF,          1,1,32'h200,32'h12345678,0,32'h8C0A0004,0,da,1);
    row(0,0,0,1,1,32'h200,32'h12345678,0,          0,0,0,0,0,32'h8C0A0004,1,da,0);
    row(0,0,0,0,0,0,0,0,                           0,0,0,0,0,32'h8C0A0004,0,da,0);
    // reset in the first fetch access cycle aborts it and clears the read registers
    row(0,1,32'h40,0,0,0,0,0,              0,0,0,0,0,32'h8C0A0004,0,da,1);
    row(1,1,32'h40,0,0,0,0,0,              1,0,32'h40,32'h12345678,0,32'h8C0A0004,0,da,1);
    row(0,0,0,0,0,0,0,32'h77777777,        0,0,0,0,0,0,0,0,0);
    row(0,0,0,0,0,0,0,32'h77777777,        0,0,0,0,0,0,0,0,0);
`ifdef FETCH_BUF_EN
    // fetch 0x10 fills the buffer, refetch hits, a store to 0x10 invalidates it
    row(0,1,32'h10,0,0,0,0,0,              0,0,0,0,0,0,0,0,1);
    row(0,1,32'h10,0,0,0,0,0,              1,0,32'h10,0,0,0,0,0,1);
    row(0,1,32'h10,0,0,0,0,32'h55,         1,0,32'h10,0,0,0,0,0,1);
    row(0,1,32'h10,0,0,0,0,0,              0,0,0,0,1,32'h55,0,0,0);
    row(0,0,0,0,0,0,0,0,                   0,0,0,0,0,32'h55,0,0,0);
    row(0,1,32'h10,0,0,0,0,32'h99,         0,0,0,0,1,32'h55,0,0,0);
    row(0,0,0,0,0,0,0,0,                   0,0,0,0,0,32'h55,0,0,0);
    row(0,0,0,1,1,32'h10,32'hAA,0,         0,0,0,0,0,32'h55,0,0,1);
    row(0,0,0,1,1,32'h10,32'hAA,0,         1,1,32'h10,32'hAA,0,32'h55,0,0,1);
    row(0,0,0,1,1,32'h10,32'hAA,0,         1,1,32'h10,32'hAA,0,32'h55,0,0,1);
    row(0,0,0,1,1,32'h10,32'hAA,0,         0,0,0,0,0,32'h55,1,0,0);
    row(0,1,32'h10,0,0,0,0,0,              0,0,0,0,0,32'h55,0,0,1);
    row(0,1,32'h10,0,0,0,0,0,              1,0,32'h10,32'hAA,0,32'h55,0,0,1);
    row(0,1,32'h10,0,0,0,0,32'h66,         1,0,32'h10,32'hAA,0,32'h55,0,0,1);
    row(0,1,32'h10,0,0,0,0,0,              0,0,0,0,1,32'h66,0,0,0);
    row(0,0,0,0,0,0,0,0,                   0,0,0,0,0,32'h66,0,0,0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      reset = vecs[i].rst; if_req = vecs[i].ireq; if_addr = vecs[i].iaddr;
      d_req = vecs[i].dreq; d_we = vecs[i].dwe; d_addr = vecs[i].daddr;
      d_wdata = vecs[i].dwd; mem_rdata = vecs[i].mrd;
      #1;
      check($sformatf("row%0d", i), outs(),
            {vecs[i].en, vecs[i].we, vecs[i].maddr, vecs[i].mwd, vecs[i].ir,
             vecs[i].ird, vecs[i].dr, vecs[i].drd, vecs[i].st});
    end

    // fetch latency from idle: ready in the LAT+2'th cycle (index 3)
    @(negedge clock);
    reset = 1'b0; d_req = 1'b0; d_we = 1'b0; if_req = 1'b1; if_addr = 32'h80;
    mem_rdata = 32'h13579BDF;
    #1;
    k = 0;
    while (k < 20 && !if_ready) begin
      @(negedge clock); #1; k++;
    end
    check("fetch_latency", 133'(k), 133'(3));
    check("fetch_data", 133'(if_rdata), 133'(32'h13579BDF));
    @(negedge clock);
    if_req = 1'b0;

    // load request dropped after being latched still completes and pulses d_ready
    @(negedge clock);
    d_req = 1'b1; d_addr = 32'h84; mem_rdata = 32'h2468ACE0;
    @(negedge clock);
    d_req = 1'b0; d_addr = '0;
    #1;
    check("drop_stall", 133'(stall), 133'(0));
    check("drop_mem", 133'({mem_en, mem_addr}), 133'({1'b1, 32'h84}));
    k = 1;
    while (k < 20 && !d_ready) begin
      @(negedge clock); #1; k++;
    end
    check("drop_latency", 133'(k), 133'(3));
    check("drop_data", 133'(d_rdata), 133'(32'h2468ACE0));
    @(negedge clock);
    #1;
    check("drop_idle", 133'({mem_en, d_ready, stall}), 133'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
